// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR phase-select controller.
package cdr_pkg;

  typedef enum logic {CDR_ACQ = 1'b0, CDR_TRACK = 1'b1} cdr_state_e;

  // ea - la spans -3..+3, which needs a 3-bit signed value
  localparam int DIFF_W = 3;

  function automatic int sat_add(input int a, input int b, input int w);
    int s, hi, lo;
    s  = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/cdr_loop_filter.sv
// Saturating early/late integrator with a mode-dependent step threshold.
module cdr_loop_filter
  import cdr_pkg::*;
#(
  parameter int ACC_W  = 4,
  parameter int THRESH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       proc,
  input  cdr_state_e state,
  input  logic [1:0] ea,
  input  logic [1:0] la,
  output logic       step,
  output logic       dir
);

  localparam int THR_ACQ = ((THRESH >> 1) > 1) ? (THRESH >> 1) : 1;

  logic signed [DIFF_W-1:0] d;
  logic signed [ACC_W-1:0]  acc, acc_n;
  int                       thr;
  logic                     hit_dn, hit_up;

  assign d      = $signed({1'b0, ea}) - $signed({1'b0, la});
  assign acc_n  = ACC_W'(sat_add(int'(acc), int'(d), ACC_W));
  assign thr    = (state == CDR_TRACK) ? THRESH : THR_ACQ;
  assign hit_dn = int'(acc_n) >= thr;
  assign hit_up = int'(acc_n) <= -thr;

  // dir: 1 = increment the phase index (too many late votes)
  assign step = proc && (hit_dn || hit_up);
  assign dir  = hit_up;

  always_ff @(posedge clk) begin
    if (rst)       acc <= '0;
    else if (proc) acc <= step ? '0 : acc_n;
  end

endmodule

// File: rtl/cdr_phase_ctrl.sv
// CDR phase-select controller: strobe detect, holdoff/lock/run counters, ACQ/TRACK FSM.
module cdr_phase_ctrl
  import cdr_pkg::*;
#(
  parameter int PH_BITS  = 3,
  parameter int PH_INIT  = 0,
  parameter int ACC_W    = 4,
  parameter int THRESH   = 4,
  parameter int HOLDOFF  = 2,
  parameter int LOCK_WIN = 16,
  parameter int RUN_LIM  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vote_clk,
  input  logic [1:0]         ea,
  input  logic [1:0]         la,
  input  logic               freeze,
  output logic [PH_BITS-1:0] ph_sel,
  output logic               ph_step,
  output logic               ph_dir,
  output logic               locked
);

  localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int LK_W = $clog2(LOCK_WIN + 1);
  localparam int RN_W = $clog2(RUN_LIM + 1);

  cdr_state_e         state, state_n;
  logic               vote_clk_q;
  logic [HO_W-1:0]    ho_cnt, ho_n;
  logic [LK_W-1:0]    lock_cnt, lock_n;
  logic [RN_W-1:0]    run_cnt, run_n;
  logic [PH_BITS-1:0] ph_n;
  logic               dir_n, step_n;
  logic               stb, act, ho_busy, proc, step, step_dir;

  assign stb     = vote_clk & ~vote_clk_q;
  assign act     = stb & ~freeze;
  assign ho_busy = (ho_cnt != '0);
  assign proc    = act & ~ho_busy;
  assign locked  = (state == CDR_TRACK);

  cdr_loop_filter #(.ACC_W(ACC_W), .THRESH(THRESH)) u_lf (
    .clk  (clk),
    .rst  (rst),
    .proc (proc),
    .state(state),
    .ea   (ea),
    .la   (la),
    .step (step),
    .dir  (step_dir)
  );

  always_comb begin
    state_n = state;
    ho_n    = ho_cnt;
    lock_n  = lock_cnt;
    run_n   = run_cnt;
    ph_n    = ph_sel;
    dir_n   = ph_dir;
    step_n  = 1'b0;
    if (act) begin
      if (ho_busy) begin
        ho_n = ho_cnt - HO_W'(1);
      end else if (step) begin
        step_n = 1'b1;
        dir_n  = step_dir;
        ph_n   = step_dir ? ph_sel + PH_BITS'(1) : ph_sel - PH_BITS'(1);
        ho_n   = HO_W'(HOLDOFF);
        lock_n = '0;
        // ph_dir still holds the previous step direction here
        if (step_dir != ph_dir)            run_n = RN_W'(1);
        else if (run_cnt != RN_W'(RUN_LIM)) run_n = run_cnt + RN_W'(1);
        if (state == CDR_TRACK && run_n == RN_W'(RUN_LIM)) begin
          state_n = CDR_ACQ;
          run_n   = '0;
        end
      end else begin
        if (lock_cnt != LK_W'(LOCK_WIN)) lock_n = lock_cnt + LK_W'(1);
        if (state == CDR_ACQ && lock_n == LK_W'(LOCK_WIN)) begin
          state_n = CDR_TRACK;
          run_n   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CDR_ACQ;
      vote_clk_q <= 1'b0;
      ho_cnt     <= '0;
      lock_cnt   <= '0;
      run_cnt    <= '0;
      ph_sel     <= PH_BITS'(PH_INIT);
      ph_dir     <= 1'b0;
      ph_step    <= 1'b0;
    end else begin
      state      <= state_n;
      vote_clk_q <= vote_clk;
      ho_cnt     <= ho_n;
      lock_cnt   <= lock_n;
      run_cnt    <= run_n;
      ph_sel     <= ph_n;
      ph_dir     <= dir_n;
      ph_step    <= step_n;
    end
  end

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// Directed bench for cdr_phase_ctrl at default parameters.
module tb_cdr_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst, vote_clk, freeze;
  logic [1:0] ea, la;
  logic [2:0] ph_sel;
  logic       ph_step, ph_dir, locked;

  int n_cmp = 0;
  int n_err = 0;

  cdr_phase_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .vote_clk(vote_clk),
    .ea      (ea),
    .la      (la),
    .freeze  (freeze),
    .ph_sel  (ph_sel),
    .ph_step (ph_step),
    .ph_dir  (ph_dir),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One vote window: rising vote_clk, result sampled after the strobe edge,
  // then the pulse must be gone one edge later.
  task automatic vote(input logic [1:0] e, input logic [1:0] l, input logic frz,
                      output logic pulse);
    @(negedge clk);
    ea = e; la = l; freeze = frz; vote_clk = 1'b1;
    @(posedge clk); #1;
    pulse = ph_step;
    @(negedge clk);
    vote_clk = 1'b0; freeze = 1'b0;
    @(posedge clk); #1;
    chk("step_clr", ph_step, 1'b0);
  endtask

  task automatic vote_exp(input string tag, input logic [1:0] e, input logic [1:0] l,
                          input logic frz, input logic exp_pulse, input logic [2:0] exp_ph);
    logic p;
    vote(e, l, frz, p);
    chk({tag, "_pulse"}, p, exp_pulse);
    chk({tag, "_ph"}, ph_sel, exp_ph);
  endtask

  initial begin
    rst = 1'b1; vote_clk = 1'b0; freeze = 1'b0; ea = '0; la = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ph", ph_sel, 3'd0);
    chk("rst_lock", locked, 1'b0);
    chk("rst_step", ph_step, 1'b0);
    chk("rst_dir", ph_dir, 1'b0);
    @(negedge clk) rst = 1'b0;

    // ACQ threshold 2: +2 steps down, 0 wraps to 7
    vote_exp("acq_step", 2'd2, 2'd0, 1'b0, 1'b1, 3'd7);
    chk("acq_dir", ph_dir, 1'b0);

    // holdoff swallows two strobes, third steps again
    vote_exp("ho1", 2'd3, 2'd0, 1'b0, 1'b0, 3'd7);
    vote_exp("ho2", 2'd3, 2'd0, 1'b0, 1'b0, 3'd7);
    vote_exp("ho_done", 2'd3, 2'd0, 1'b0, 1'b1, 3'd6);
    vote_exp("ho3", 2'd0, 2'd0, 1'b0, 1'b0, 3'd6);
    vote_exp("ho4", 2'd0, 2'd0, 1'b0, 1'b0, 3'd6);

    // 16 balanced windows to lock
    for (int i = 1; i <= 16; i++) begin
      vote_exp("bal", 2'd1, 2'd1, 1'b0, 1'b0, 3'd6);
      if (i == 15) chk("lock15", locked, 1'b0);
    end
    chk("lock16", locked, 1'b1);

    // TRACK threshold 4: -3 holds, -6 steps up
    vote_exp("trk_m3", 2'd0, 2'd3, 1'b0, 1'b0, 3'd6);
    vote_exp("trk_m6", 2'd0, 2'd3, 1'b0, 1'b1, 3'd7);
    chk("trk_dir", ph_dir, 1'b1);
    vote_exp("trk_ho1", 2'd0, 2'd3, 1'b0, 1'b0, 3'd7);
    vote_exp("trk_ho2", 2'd0, 2'd0, 1'b0, 1'b0, 3'd7);
    chk("trk_still", locked, 1'b1);

    // four consecutive decrements drop lock on the fourth
    for (int k = 1; k <= 4; k++) begin
      vote_exp("run_a", 2'd3, 2'd0, 1'b0, 1'b0, 3'(7 - k + 1));
      vote_exp("run_b", 2'd3, 2'd0, 1'b0, 1'b1, 3'(7 - k));
      chk("run_lock", locked, (k < 4) ? 1'b1 : 1'b0);
      vote_exp("run_ho1", 2'd0, 2'd0, 1'b0, 1'b0, 3'(7 - k));
      vote_exp("run_ho2", 2'd0, 2'd0, 1'b0, 1'b0, 3'(7 - k));
    end
    chk("run_dir", ph_dir, 1'b0);

    // freeze holds acc: frozen +1 must not count toward the next step
    vote_exp("frz3", 2'd3, 2'd0, 1'b1, 1'b0, 3'd3);
    vote_exp("frz1", 2'd1, 2'd0, 1'b1, 1'b0, 3'd3);
    vote_exp("thaw1", 2'd1, 2'd0, 1'b0, 1'b0, 3'd3);
    vote_exp("thaw2", 2'd1, 2'd0, 1'b0, 1'b1, 3'd2);

    // walk up to 5 in ACQ, leave acc at +1
    for (int k = 3; k <= 5; k++) begin
      vote_exp("up_ho1", 2'd0, 2'd0, 1'b0, 1'b0, 3'(k - 1));
      vote_exp("up_ho2", 2'd0, 2'd0, 1'b0, 1'b0, 3'(k - 1));
      vote_exp("up", 2'd0, 2'd3, 1'b0, 1'b1, 3'(k));
    end
    vote_exp("pre_ho1", 2'd0, 2'd0, 1'b0, 1'b0, 3'd5);
    vote_exp("pre_ho2", 2'd0, 2'd0, 1'b0, 1'b0, 3'd5);
    vote_exp("pre_acc", 2'd1, 2'd0, 1'b0, 1'b0, 3'd5);

    // mid-run reset
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_ph", ph_sel, 3'd0);
    chk("mid_rst_lock", locked, 1'b0);
    chk("mid_rst_step", ph_step, 1'b0);
    @(negedge clk) rst = 1'b0;
    // acc cleared: first +1 holds, second reaches the ACQ threshold
    vote_exp("post_rst1", 2'd1, 2'd0, 1'b0, 1'b0, 3'd0);
    vote_exp("post_rst2", 2'd1, 2'd0, 1'b0, 1'b1, 3'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
